// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle MIPS multiply/divide unit with HI/LO result registers
// Ports:
//   clk_i, reset_i   clock; synchronous active-high reset
//   start_i, op_i    request and opcode (000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op)
//   a_i, b_i         operands rs/rt, latched when a request is accepted
//   flush_i          cancels an in-flight op or blocks an accept; HI/LO untouched
//   busy_o, done_o   mul/div in flight; one-cycle pulse when new HI/LO become visible
//   hi_o, lo_o       HI (product high / remainder), LO (product low / quotient)
module mul_div_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2((WIDTH + 2 > MUL_STAGES ? WIDTH + 2 : MUL_STAGES) + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_STAGES - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t             state_q;
    logic               busy_q, done_q, sgn_q;
    logic [WIDTH-1:0]   hi_q, lo_q, a_q, b_q, rem_q, quo_q, dvs_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] prod_q [MUL_STAGES];

    logic               sgn_d, fit_d, neg_q_d, neg_r_d;
    logic [2*WIDTH-1:0] ax_d, bx_d, prod_d;
    logic [WIDTH-1:0]   mag_a_d, mag_b_d;
    logic [WIDTH:0]     sh_d;

    // Even opcodes are the signed variants; sign-extending to 2*WIDTH lets one
    // unsigned multiplier produce both signed and unsigned products.
    assign sgn_d   = ~op_i[0];
    assign ax_d    = {{WIDTH{sgn_d & a_i[WIDTH-1]}}, a_i};
    assign bx_d    = {{WIDTH{sgn_d & b_i[WIDTH-1]}}, b_i};
    assign prod_d  = ax_d * bx_d;
    assign mag_a_d = (sgn_q & a_q[WIDTH-1]) ? -a_q : a_q;
    assign mag_b_d = (sgn_q & b_q[WIDTH-1]) ? -b_q : b_q;
    // Partial remainder shifted left with the next dividend bit pulled in from quo_q.
    assign sh_d    = {rem_q, quo_q[WIDTH-1]};
    assign fit_d   = sh_d >= {1'b0, dvs_q};
    assign neg_q_d = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    assign neg_r_d = sgn_q & a_q[WIDTH-1];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sgn_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < MUL_STAGES; i++) prod_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            for (int i = 1; i < MUL_STAGES; i++) prod_q[i] <= prod_q[i-1];
            case (state_q)
                IDLE: if (start_i && !flush_i) begin
                    a_q       <= a_i;
                    b_q       <= b_i;
                    sgn_q     <= sgn_d;
                    cnt_q     <= '0;
                    prod_q[0] <= prod_d;
                    case (op_i)
                        3'b000, 3'b001: begin state_q <= MUL; busy_q <= 1'b1; end
                        3'b010, 3'b011: begin state_q <= DIV; busy_q <= 1'b1; end
                        3'b100: hi_q <= a_i;
                        3'b101: lo_q <= a_i;
                        default: ;
                    endcase
                end
                MUL: if (flush_i) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end else if (cnt_q == MUL_LAST) begin
                    {hi_q, lo_q} <= prod_q[MUL_STAGES-1];
                    state_q      <= IDLE;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
                DIV: if (flush_i) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end else if (cnt_q == '0) begin
                    rem_q <= '0;
                    quo_q <= mag_a_d;
                    dvs_q <= mag_b_d;
                    cnt_q <= cnt_q + CW'(1);
                end else if (cnt_q == DIV_LAST) begin
                    // Divide by zero bypasses the iteration result entirely.
                    hi_q    <= (b_q == '0) ? a_q : (neg_r_d ? -rem_q : rem_q);
                    lo_q    <= (b_q == '0) ? '1 : (neg_q_d ? -quo_q : quo_q);
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    rem_q <= fit_d ? sh_d[WIDTH-1:0] - dvs_q : sh_d[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], fit_d};
                    cnt_q <= cnt_q + CW'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed bench for mul_div_unit with an arithmetic reference model
module tb_mul_div_unit;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0, b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int          checks = 0, failures = 0;

    mul_div_unit #(.WIDTH(32), .MUL_STAGES(3)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .flush_i(flush), .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy;
        logic [63:0] ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            3'b000:  return sx * sy;
            3'b001:  return ux * uy;
            3'b010:  return (y == 0) ? {x, 32'hFFFFFFFF} : {32'(sx % sy), 32'(sx / sy)};
            3'b011:  return (y == 0) ? {x, 32'hFFFFFFFF} : {32'(ux % uy), 32'(ux / uy)};
            default: return 64'b0;
        endcase
    endfunction

    logic        m_init = 1'b0, m_busy, m_done;
    logic [31:0] m_hi, m_lo, m_rhi, m_rlo;
    int          m_left;

    always @(posedge clk) begin
        if (reset) begin
            m_init <= 1'b1;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (flush) m_busy <= 1'b0;
                else if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_hi   <= m_rhi;
                    m_lo   <= m_rlo;
                end else m_left <= m_left - 1;
            end else if (start && !flush) begin
                if (!op[2]) begin
                    {m_rhi, m_rlo} <= model_result(op, a, b);
                    m_left         <= op[1] ? 34 : 3;
                    m_busy         <= 1'b1;
                end else if (op == 3'b100) m_hi <= a;
                else if (op == 3'b101) m_lo <= a;
            end
        end
    end

    always @(negedge clk) if (m_init) begin
        checks++;
        if (busy !== m_busy || done !== m_done || hi !== m_hi || lo !== m_lo) begin
            failures++;
            $display("FAIL model t=%0t busy=%b/%b done=%b/%b hi=%h/%h lo=%h/%h (got/expected)",
                     $time, busy, m_busy, done, m_done, hi, m_hi, lo, m_lo);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
    endtask

    task automatic run_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    int n, dones;

    initial begin
        repeat (2) @(negedge clk);
        check("reset_state", {busy, done, hi, lo}, 66'b0);
        reset = 1'b0;

        issue(3'b000, 32'hFFFFFFFD, 32'h00000005);
        run_busy(n);
        check("mult_latency", 64'(n), 64'd3);
        check("mult_done", {63'b0, done}, 64'd1);
        check("mult_result", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
        @(negedge clk);
        check("mult_done_once", {63'b0, done}, 64'd0);

        issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_busy(n);
        check("multu_result", {hi, lo}, 64'hFFFFFFFE_00000001);
        start = 1'b1; op = 3'b101; a = 32'h12345678;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_b2b", {hi, lo}, 64'hFFFFFFFE_12345678);

        issue(3'b010, 32'hFFFFFFF9, 32'h00000002);
        run_busy(n);
        check("div_latency", 64'(n), 64'd34);
        check("div_done", {63'b0, done}, 64'd1);
        check("div_result", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        issue(3'b011, 32'hFFFFFFF9, 32'h00000002);
        run_busy(n);
        check("divu_result", {hi, lo}, 64'h00000001_7FFFFFFC);

        issue(3'b011, 32'h0000000A, 32'h0);
        run_busy(n);
        check("divu_by_zero_latency", 64'(n), 64'd34);
        check("divu_by_zero", {hi, lo}, 64'h0000000A_FFFFFFFF);
        issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
        run_busy(n);
        check("div_overflow", {hi, lo}, 64'h00000000_80000000);

        issue(3'b100, 32'h1111, 32'h0);
        issue(3'b101, 32'h2222, 32'h0);
        @(negedge clk);
        start = 1'b1; op = 3'b010; a = 32'd100; b = 32'd7;
        @(negedge clk);
        op = 3'b100; a = 32'hDEAD;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        check("flush_div", {busy, done, hi, lo}, {2'b00, 32'h1111, 32'h2222});

        @(negedge clk);
        start = 1'b1; op = 3'b100; a = 32'h99; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_blocks_mthi", {32'b0, hi}, 64'h1111);

        issue(3'b110, 32'h77, 32'h1);
        check("noop_ignored", {busy, hi, lo}, {1'b0, 32'h1111, 32'h2222});

        issue(3'b000, 32'd2, 32'd3);
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_at_complete", {busy, done, hi, lo}, {2'b00, 32'h1111, 32'h2222});

        issue(3'b100, 32'h55, 32'h0);
        check("mthi_55", {32'b0, hi}, 64'h55);
        issue(3'b000, 32'd3, 32'd4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_midmul", {busy, done, hi, lo}, 66'b0);
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("no_done_after_reset", 64'(dones), 64'd0);

        issue(3'b000, 32'h7FFFFFFF, 32'h80000000);
        run_busy(n);
        check("mult_extremes", {hi, lo}, 64'hC0000000_80000000);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
